// File: rtl/cl2_csr_rmw.sv
// cl2_csr_rmw: CSR read-modify-write sequencer between pipeline and CSR field bank
module cl2_csr_rmw #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_src_i,
  input  logic              req_src_zero_i,
  input  logic [1:0]        priv_i,
  output logic [ADDR_W-1:0] csr_addr_o,
  input  logic [XLEN-1:0]   csr_rd_dat_i,
  input  logic              csr_exist_i,
  output logic              csr_wr_en_o,
  output logic [XLEN-1:0]   csr_wr_dat_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rd_dat_o,
  output logic              rsp_illegal_o
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
  state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0] src_q, src_d, old_q, old_d, wr_dat_q, wr_dat_d, rsp_rd_q, rsp_rd_d, new_val;
  logic src_zero_q, src_zero_d, illegal_q, illegal_d, wr_en_q, wr_en_d;
  logic rsp_valid_q, rsp_valid_d, rsp_ill_q, rsp_ill_d;
  logic accept, in_read, in_write, intent;
  // Next-state and datapath: capture in IDLE, evaluate in READ, pulse in WRITE, present in RESP
  always_comb begin
    accept      = (state_q == IDLE) & req_valid_i;
    in_read     = state_q == READ;
    in_write    = state_q == WRITE;
    intent      = (op_q == 2'b01) | ((op_q != 2'b00) & ~src_zero_q);
    new_val     = op_q == 2'b01 ? src_q : op_q == 2'b10 ? (csr_rd_dat_i | src_q) : (csr_rd_dat_i & ~src_q);
    state_d     = state_q == IDLE ? (req_valid_i ? READ : IDLE) :
                  state_q == READ ? WRITE :
                  state_q == WRITE ? RESP : (rsp_ready_i ? IDLE : RESP);
    op_d        = accept ? req_op_i : op_q;
    addr_d      = accept ? req_addr_i : addr_q;
    src_d       = accept ? req_src_i : src_q;
    src_zero_d  = accept ? req_src_zero_i : src_zero_q;
    old_d       = in_read ? csr_rd_dat_i : old_q;
    illegal_d   = in_read ? ((op_q == 2'b00) | ~csr_exist_i | (priv_i < addr_q[9:8]) |
                             ((addr_q[11:10] == 2'b11) & intent)) : illegal_q;
    wr_en_d     = in_read & intent & ~illegal_d;
    wr_dat_d    = in_read ? new_val : wr_dat_q;
    rsp_valid_d = in_write | (rsp_valid_q & ~rsp_ready_i);
    rsp_rd_d    = in_write ? (illegal_q ? '0 : old_q) : rsp_rd_q;
    rsp_ill_d   = in_write ? illegal_q : rsp_ill_q;
  end
  // State and registered outputs; async reset kills any in-flight write pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      src_q       <= '0;
      src_zero_q  <= 1'b0;
      old_q       <= '0;
      illegal_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_dat_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      src_q       <= src_d;
      src_zero_q  <= src_zero_d;
      old_q       <= old_d;
      illegal_q   <= illegal_d;
      wr_en_q     <= wr_en_d;
      wr_dat_q    <= wr_dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end
  assign req_ready_o   = state_q == IDLE;
  assign csr_addr_o    = addr_q;
  assign csr_wr_en_o   = wr_en_q;
  assign csr_wr_dat_o  = wr_dat_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rd_dat_o  = rsp_rd_q;
  assign rsp_illegal_o = rsp_ill_q;
endmodule

// File: tb/tb_cl2_csr_rmw.sv
// tb_cl2_csr_rmw: randomized self-checking bench with a CSR bank and transaction-level reference
module tb_cl2_csr_rmw;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready, req_src_zero = 1'b0, csr_exist, csr_wr_en;
  logic rsp_valid, rsp_ready = 1'b0, rsp_illegal;
  logic [1:0] req_op = 2'b00, priv = 2'd3;
  logic [11:0] req_addr = '0, csr_addr;
  logic [31:0] req_src = '0, csr_rd_dat, csr_wr_dat, rsp_rd_dat;
  logic [31:0] mem [4096];
  logic ex [4096];
  logic poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [31:0] poke_d = '0;
  int wr_cnt = 0, n_chk = 0, n_pass = 0;
  cl2_csr_rmw dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_src_i(req_src), .req_src_zero_i(req_src_zero),
    .priv_i(priv), .csr_addr_o(csr_addr), .csr_rd_dat_i(csr_rd_dat), .csr_exist_i(csr_exist),
    .csr_wr_en_o(csr_wr_en), .csr_wr_dat_o(csr_wr_dat), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_rd_dat_o(rsp_rd_dat), .rsp_illegal_o(rsp_illegal)
  );
  always #5 clk = ~clk;
  assign csr_rd_dat = mem[csr_addr];
  assign csr_exist  = ex[csr_addr];
  // Field bank: takes DUT writes, or bench preloads between transactions
  always @(posedge clk) begin
    if (csr_wr_en) begin
      mem[csr_addr] <= csr_wr_dat;
      wr_cnt <= wr_cnt + 1;
    end else if (poke_en) mem[poke_a] <= poke_d;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask
  task automatic txn(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src,
                     input logic sz, input logic [1:0] pr, input logic e, input int bp);
    logic [31:0] old, nv, erd;
    logic ill, we, wants;
    int c0;
    ex[a] = e;
    old = mem[a];
    wants = (op == 2'b01) || (op != 2'b00 && !sz);
    ill = (op == 2'b00) || !e || (int'(pr) < int'(a[9:8])) || (a[11:10] == 2'b11 && wants);
    we = wants && !ill;
    case (op)
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      default: nv = old & ~src;
    endcase
    erd = ill ? 32'h0 : old;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_src = src; req_src_zero = sz; priv = pr;
    c0 = wr_cnt;
    @(posedge clk); #1;
    req_op = ~op; req_addr = ~a; req_src = ~src; req_src_zero = ~sz;
    @(negedge clk);
    chk("addr_read", csr_addr, a);
    chk("busy_ready", req_ready, 0);
    chk("we_early", csr_wr_en, 0);
    chk("rsp_early", rsp_valid, 0);
    @(negedge clk);
    chk("we_pulse", csr_wr_en, we);
    if (we) chk("wr_dat", csr_wr_dat, nv);
    chk("rsp_in_write", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rd", rsp_rd_dat, erd);
    chk("rsp_ill", rsp_illegal, ill);
    chk("we_after", csr_wr_en, 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rd", rsp_rd_dat, erd);
      chk("bp_ill", rsp_illegal, ill);
      chk("bp_ready", req_ready, 0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
    chk("we_count", wr_cnt - c0, we);
    chk("mem", mem[a], we ? nv : old);
  endtask
  initial begin
    logic [11:0] pool [8];
    logic [1:0] pv [3];
    int c0;
    pool = '{12'h340, 12'h300, 12'h305, 12'hF14, 12'h100, 12'h001, 12'hC00, 12'h7C0};
    pv = '{2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; ex[i] = 1'b1; end
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_we", csr_wr_en, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ill", rsp_illegal, 0);
    chk("rst_addr", csr_addr, 0);
    chk("rst_wdat", csr_wr_dat, 0);
    chk("rst_rd", rsp_rd_dat, 0);
    rst = 1'b0;
    poke(12'h340, 32'h1234);
    txn(2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 2'd3, 1'b1, 0);
    poke(12'h340, 32'h00F0);
    txn(2'b10, 12'h340, 32'h000F, 1'b0, 2'd3, 1'b1, 0);
    txn(2'b11, 12'h340, 32'h00F0, 1'b0, 2'd3, 1'b1, 0);
    txn(2'b10, 12'h340, 32'h0, 1'b1, 2'd3, 1'b1, 0);
    poke(12'hF14, 32'd5);
    txn(2'b01, 12'hF14, 32'd7, 1'b0, 2'd3, 1'b1, 0);
    txn(2'b10, 12'hF14, 32'd0, 1'b1, 2'd3, 1'b1, 0);
    txn(2'b01, 12'h300, 32'd1, 1'b0, 2'd0, 1'b1, 0);
    txn(2'b01, 12'h341, 32'd1, 1'b0, 2'd3, 1'b0, 0);
    txn(2'b00, 12'h340, 32'd1, 1'b0, 2'd3, 1'b1, 0);
    txn(2'b01, 12'h340, 32'hABCD, 1'b0, 2'd3, 1'b1, 5);
    poke(12'h340, 32'h55);
    @(negedge clk);
    c0 = wr_cnt;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h340; req_src = 32'h99; req_src_zero = 1'b0; priv = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst_we", csr_wr_en, 0);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_addr", csr_addr, 0);
    chk("midrst_wdat", csr_wr_dat, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cnt", wr_cnt - c0, 0);
    chk("midrst_mem", mem[12'h340], 32'h55);
    chk("midrst_rdy2", req_ready, 1);
    for (int k = 0; k < 40; k++) begin
      logic [11:0] a;
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) poke(a, $urandom);
      txn(2'($urandom_range(0, 3)), a, $urandom, 1'($urandom_range(0, 1)),
          pv[$urandom_range(0, 2)], $urandom_range(0, 6) != 0, $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cl2_csr_rmw.md
Name: cl2_csr_rmw

Overview:
- CSR read-modify-write sequencer; sits directly upstream of the CSR field registers.
- Accepts one CSR instruction request (RW/RS/RC) per transaction and reads the addressed CSR through the field read mux.
- Checks access legality, then issues a single-cycle write-enable/data pulse to the field bank.
- Returns the old CSR value and an illegal flag to the pipeline over a valid/ready response.

Parameters:
- XLEN, 32, CSR data width and field write-data width
- ADDR_W, 12, CSR address width (RISC-V encoding: [11:10] rw/ro, [9:8] min privilege)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  2  00 reserved, 01 RW, 10 RS (set), 11 RC (clear)
- req_addr_i  in  ADDR_W  CSR address
- req_src_i  in  XLEN  rs1 value or zero-extended zimm
- req_src_zero_i  in  1  rs1 index / zimm is zero (suppresses RS/RC write)
- priv_i  in  2  current privilege level (0 U, 1 S, 3 M)
- csr_addr_o  out  ADDR_W  address to field read mux / write decode
- csr_rd_dat_i  in  XLEN  combinational read data for csr_addr_o
- csr_exist_i  in  1  combinational: csr_addr_o is implemented
- csr_wr_en_o  out  1  one-cycle write enable to field bank
- csr_wr_dat_o  out  XLEN  write data to field bank
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rd_dat_o  out  XLEN  old CSR value (rd writeback)
- rsp_illegal_o  out  1  illegal-instruction indication

Behaviour:
- Reset (async on rst_i rising, held while high):
  - state IDLE.
  - req_ready_o=1; csr_wr_en_o, rsp_valid_o and rsp_illegal_o = 0.
  - csr_addr_o, csr_wr_dat_o and rsp_rd_dat_o = 0.
- FSM IDLE -> READ -> WRITE -> RESP -> IDLE.
  - req_ready_o = (state==IDLE), computed combinationally from state only.
- IDLE: on req_valid_i & req_ready_o, register op, addr, src, src_zero; go to READ.
- READ (1 cycle):
  - csr_addr_o = captured addr (held registered from here through RESP).
  - Sample csr_rd_dat_i into old.
  - Compute new: RW src; RS old|src; RC old&~src.
  - Register illegal and write-intent; go to WRITE.
- Write intent = (op==RW) | (op!=00 & ~src_zero).
- Illegal if any of the following:
  - op==00;
  - ~csr_exist_i;
  - priv_i < addr[9:8] (unsigned);
  - addr[11:10]==2'b11 with write intent.
  - A read-only CSR read via RS/RC with src_zero is legal.
- WRITE (1 cycle):
  - csr_wr_en_o = intent & ~illegal; csr_wr_dat_o = new.
  - csr_wr_en_o is high for exactly this cycle and only in this state; go to RESP.
  - Field updates on the following edge.
- RESP:
  - rsp_valid_o=1; rsp_rd_dat_o = old (0 if illegal); rsp_illegal_o as computed.
  - Hold all response outputs stable until rsp_ready_i; on handshake go to IDLE.
  - rsp_valid_o deasserts next cycle.
- Latency:
  - Accept at edge N; csr_wr_en_o high during cycle N+2; rsp_valid_o first high in cycle N+3.
  - Fixed, independent of legality.
  - Next request can be accepted the cycle after the response handshake; no overlap, no bypass.
- Boundary conditions:
  - req_valid_i outside IDLE is ignored.
  - rsp_ready_i outside RESP is ignored.
  - Reset mid-transaction: return to IDLE with no write pulse emitted, even if reset lands during WRITE.
  - Arithmetic is bitwise only; widths are XLEN throughout.

Test Plan:
- RW legal: priv=3, addr 0x340, csr value 0x1234, src 0xDEADBEEF -> wr_en pulse N+2 with 0xDEADBEEF; rsp N+3 rd=0x1234, illegal=0.
- RS/RC: value 0x00F0, RS src 0x000F -> write 0x00FF; then RC src 0x00F0 on the new value -> write 0x000F; RS with src_zero=1 -> no wr_en, rd=current value.
- Read-only CSR: addr 0xF14, value 5.
  - RW -> illegal=1, no wr_en, rd=0.
  - RS src_zero=1 -> legal, rd=5.
- Privilege/existence:
  - priv=0, addr 0x300 -> illegal.
  - csr_exist_i=0 -> illegal.
  - op=00 -> illegal.
  - In all three cases no wr_en.
- Backpressure: rsp_ready_i low 5 cycles -> rsp outputs stable, req_ready_o low throughout; a new request is accepted only the cycle after the handshake.
- Reset during WRITE cycle -> no wr_en observed, outputs return to reset values, req_ready_o=1 after reset deasserts.
